// File: rtl/adc_spi_responder.sv
// SPI responder model of the touch-panel digitizer ADC: decodes the control byte,
// flags BUSY for one DCLK period, then returns a 12- or 8-bit X/Y sample MSB first.
module adc_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iADC_DCLK,
  input  logic        iADC_CS,
  input  logic        iADC_DIN,
  output logic        oADC_DOUT,
  output logic        oADC_BUSY,
  output logic        oADC_PENIRQ_n,
  input  logic [11:0] iX_POS,
  input  logic [11:0] iY_POS,
  input  logic        iPEN_DOWN,
  output logic [7:0]  oCMD,
  output logic        oCMD_VALID
);

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned CMD_W    = 8;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    CONV = 3'd2,
    BUSY = 3'd3,
    DATA = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] dclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] din_sync;
  logic                   dclk_d;

  logic dclk_s;
  logic cs_s;
  logic din_s;
  logic dclk_rise;
  logic dclk_fall;

  state_t              state;
  logic [CMD_W-2:0]    cmd_sr;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] data_sr;
  logic                mode_q;
  logic [SAMPLE_W-1:0] sel_sample_c;
  logic [CNT_W-1:0]    last_bit_c;

  // Pin synchronizers; CS resets deasserted so nothing starts until the master selects us
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      dclk_sync <= '0;
      cs_sync   <= '1;
      din_sync  <= '0;
      dclk_d    <= 1'b0;
    end else begin
      dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], iADC_DCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], iADC_CS};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], iADC_DIN};
      dclk_d    <= dclk_sync[SYNC_STAGES-1];
    end
  end

  assign dclk_s    = dclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign din_s     = din_sync[SYNC_STAGES-1];
  assign dclk_rise = dclk_s & ~dclk_d;
  assign dclk_fall = ~dclk_s & dclk_d;

  // Channel select from A2..A0 of the byte being completed (cmd_sr[5:3] == A2..A0)
  always_comb begin
    sel_sample_c = '0;
    if (cmd_sr[5:3] == 3'b101) begin
      sel_sample_c = iX_POS;
    end else if (cmd_sr[5:3] == 3'b001) begin
      sel_sample_c = iY_POS;
    end
  end

  assign last_bit_c = mode_q ? CNT_W'(8) : CNT_W'(12);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state         <= IDLE;
      cmd_sr        <= '0;
      bit_cnt       <= '0;
      data_sr       <= '0;
      mode_q        <= 1'b0;
      oADC_DOUT     <= 1'b0;
      oADC_BUSY     <= 1'b0;
      oADC_PENIRQ_n <= 1'b1;
      oCMD          <= '0;
      oCMD_VALID    <= 1'b0;
    end else begin
      oCMD_VALID <= 1'b0;
      if (cs_s) begin
        state         <= IDLE;
        oADC_BUSY     <= 1'b0;
        oADC_DOUT     <= 1'b0;
        oADC_PENIRQ_n <= ~iPEN_DOWN;
      end else begin
        case (state)
          IDLE: begin
            oADC_PENIRQ_n <= ~iPEN_DOWN;
            if (dclk_rise && din_s) begin
              cmd_sr  <= (CMD_W-1)'(1);
              bit_cnt <= CNT_W'(1);
              state   <= CMD;
            end
          end
          CMD: begin
            if (dclk_rise) begin
              if (bit_cnt == CNT_W'(7)) begin
                oCMD       <= {cmd_sr, din_s};
                oCMD_VALID <= 1'b1;
                data_sr    <= sel_sample_c;
                mode_q     <= cmd_sr[2];
                state      <= CONV;
              end else begin
                cmd_sr  <= {cmd_sr[CMD_W-3:0], din_s};
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          CONV: begin
            if (dclk_fall) begin
              oADC_BUSY <= 1'b1;
              state     <= BUSY;
            end
          end
          BUSY: begin
            if (dclk_fall) begin
              oADC_BUSY <= 1'b0;
              oADC_DOUT <= data_sr[SAMPLE_W-1];
              data_sr   <= {data_sr[SAMPLE_W-2:0], 1'b0};
              bit_cnt   <= CNT_W'(1);
              state     <= DATA;
            end
          end
          DATA: begin
            if (dclk_fall) begin
              if (bit_cnt == last_bit_c) begin
                oADC_DOUT <= 1'b0;
                state     <= IDLE;
              end else begin
                oADC_DOUT <= data_sr[SAMPLE_W-1];
                data_sr   <= {data_sr[SAMPLE_W-2:0], 1'b0};
                bit_cnt   <= bit_cnt + CNT_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: table of single-command reads plus
// hand sequences for reset, back-to-back, abort and pen-interrupt behaviour.
module tb_adc_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dclk;
  logic        cs;
  logic        din;
  logic        dout;
  logic        busy;
  logic        penirq_n;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic        pen_down;
  logic [7:0]  cmd;
  logic        cmd_valid;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;

  logic rx_dout [0:127];
  logic rx_busy [0:127];
  int   rx_n;

  typedef struct {
    logic [7:0]  cmd;
    int          lead;
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] exp_word;
    int          nbits;
  } vec_t;

  vec_t vecs [0:5];

  always #5 clk = ~clk;

  always @(posedge clk) if (cmd_valid === 1'b1) valid_cnt <= valid_cnt + 1;

  adc_spi_responder #(.SYNC_STAGES(2)) dut (
    .iCLK          (clk),
    .iRST_n        (rst_n),
    .iADC_DCLK     (dclk),
    .iADC_CS       (cs),
    .iADC_DIN      (din),
    .oADC_DOUT     (dout),
    .oADC_BUSY     (busy),
    .oADC_PENIRQ_n (penirq_n),
    .iX_POS        (x_pos),
    .iY_POS        (y_pos),
    .iPEN_DOWN     (pen_down),
    .oCMD          (cmd),
    .oCMD_VALID    (cmd_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One DCLK period per bit, MSB first; DOUT/BUSY captured just before each rise
  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      din = bits[i];
      repeat (6) @(negedge clk);
      rx_dout[rx_n] = dout;
      rx_busy[rx_n] = busy;
      rx_n++;
      dclk = 1'b1;
      repeat (6) @(negedge clk);
      dclk = 1'b0;
    end
  endtask

  task automatic get_word(input int first, input int nbits, output logic [11:0] w);
    w = '0;
    for (int j = 0; j < nbits; j++) w = {w[10:0], rx_dout[first + j]};
  endtask

  task automatic run_vector(input vec_t v, input int k);
    int          v0;
    int          busy_hi;
    logic [11:0] w;
    x_pos = v.x;
    y_pos = v.y;
    cs    = 1'b0;
    repeat (6) @(negedge clk);
    rx_n = 0;
    v0   = valid_cnt;
    if (v.lead > 0) send_bits(32'd0, v.lead);
    send_bits({24'd0, v.cmd}, 8);
    send_bits(32'd0, 16);
    repeat (4) @(negedge clk);
    chk($sformatf("v%0d_cmd", k), {24'd0, cmd}, {24'd0, v.cmd});
    chk($sformatf("v%0d_valid_pulses", k), valid_cnt - v0, 1);
    get_word(v.lead + 9, v.nbits, w);
    chk($sformatf("v%0d_word", k), {20'd0, w}, {20'd0, v.exp_word});
    chk($sformatf("v%0d_dout_after", k), {31'd0, rx_dout[v.lead + 9 + v.nbits]}, 0);
    busy_hi = 0;
    for (int j = 0; j < rx_n; j++) if (rx_busy[j] === 1'b1) busy_hi++;
    chk($sformatf("v%0d_busy_at_r9", k), {31'd0, rx_busy[v.lead + 8]}, 1);
    chk($sformatf("v%0d_busy_count", k), busy_hi, 1);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [11:0] w;
    int          v0;

    vecs[0] = '{cmd: 8'hD0, lead: 0, x: 12'hABC, y: 12'h000, exp_word: 12'hABC, nbits: 12};
    vecs[1] = '{cmd: 8'h98, lead: 3, x: 12'h000, y: 12'h123, exp_word: 12'h012, nbits: 8};
    vecs[2] = '{cmd: 8'h90, lead: 1, x: 12'hFFF, y: 12'h5A5, exp_word: 12'h5A5, nbits: 12};
    vecs[3] = '{cmd: 8'hDC, lead: 0, x: 12'hABC, y: 12'h000, exp_word: 12'h0AB, nbits: 8};
    vecs[4] = '{cmd: 8'hA0, lead: 2, x: 12'hFFF, y: 12'hFFF, exp_word: 12'h000, nbits: 12};
    vecs[5] = '{cmd: 8'h9F, lead: 0, x: 12'h000, y: 12'hFED, exp_word: 12'h0FE, nbits: 8};

    // Reset held with DCLK toggling and a start bit present
    rst_n    = 1'b0;
    dclk     = 1'b0;
    cs       = 1'b0;
    din      = 1'b1;
    pen_down = 1'b1;
    x_pos    = 12'hABC;
    y_pos    = 12'h000;
    rx_n     = 0;
    for (int i = 0; i < 3; i++) begin
      repeat (6) @(negedge clk);
      dclk = 1'b1;
      repeat (6) @(negedge clk);
      dclk = 1'b0;
    end
    chk("rst_dout", {31'd0, dout}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_penirq_n", {31'd0, penirq_n}, 1);
    chk("rst_cmd", {24'd0, cmd}, 0);
    chk("rst_no_valid", valid_cnt, 0);
    pen_down = 1'b0;
    cs       = 1'b1;
    din      = 1'b0;
    rst_n    = 1'b1;
    repeat (6) @(negedge clk);

    for (int k = 0; k < 6; k++) run_vector(vecs[k], k);

    // Back-to-back commands inside one CS window
    x_pos = 12'hABC;
    y_pos = 12'h5A5;
    cs    = 1'b0;
    repeat (6) @(negedge clk);
    rx_n = 0;
    v0   = valid_cnt;
    send_bits(32'hD0, 8);
    send_bits(32'd0, 16);
    send_bits(32'h90, 8);
    send_bits(32'd0, 16);
    repeat (4) @(negedge clk);
    get_word(9, 12, w);
    chk("b2b_word1", {20'd0, w}, 32'hABC);
    get_word(33, 12, w);
    chk("b2b_word2", {20'd0, w}, 32'h5A5);
    chk("b2b_valid_pulses", valid_cnt - v0, 2);
    chk("b2b_cmd", {24'd0, cmd}, 32'h90);
    cs = 1'b1;
    repeat (8) @(negedge clk);

    // Abort after data bit 5 (bit 5 of 0xABC is 1)
    cs = 1'b0;
    repeat (6) @(negedge clk);
    rx_n = 0;
    send_bits(32'hD0, 8);
    send_bits(32'd0, 5);
    repeat (4) @(negedge clk);
    chk("abort_pre_dout", {31'd0, dout}, 1);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_dout", {31'd0, dout}, 0);
    chk("abort_cmd_kept", {24'd0, cmd}, 32'hD0);
    repeat (6) @(negedge clk);
    run_vector(vecs[1], 10);

    // Pen interrupt: follows in IDLE, frozen during DATA
    cs = 1'b0;
    repeat (4) @(negedge clk);
    pen_down = 1'b1;
    @(negedge clk);
    chk("pen_idle_down", {31'd0, penirq_n}, 0);
    pen_down = 1'b0;
    @(negedge clk);
    chk("pen_idle_up", {31'd0, penirq_n}, 1);
    rx_n = 0;
    send_bits(32'hD0, 8);
    send_bits(32'd0, 12);
    pen_down = 1'b1;
    repeat (3) @(negedge clk);
    chk("pen_frozen_data", {31'd0, penirq_n}, 1);
    send_bits(32'd0, 2);
    repeat (4) @(negedge clk);
    chk("pen_after_idle", {31'd0, penirq_n}, 0);
    cs       = 1'b1;
    pen_down = 1'b0;
    repeat (3) @(negedge clk);
    chk("pen_cs_high", {31'd0, penirq_n}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Behavioural SPI slave for the touch-panel digitizer ADC: the responder end of the link that `adc_spi_controller` drives over GPIO (DCLK, CS, DIN, DOUT, BUSY, PENIRQ_n). It decodes the 8-bit control byte and asserts BUSY for one DCLK period. It then shifts out a 12- or 8-bit X/Y sample taken from its parallel inputs, and drives PENIRQ_n from a pen-down input. It lets the touch path be exercised on-board and in simulation without the LTM panel fitted.

## Interface
- SYNC_STAGES, 2, synchronizer depth on iADC_DCLK / iADC_CS / iADC_DIN (min 2)

Ports (all I/O sampled on or launched from iCLK):
- iCLK  in  1  system clock (CLOCK_50)
- iRST_n  in  1  reset; asynchronous, active-low
- iADC_DCLK  in  1  SPI clock from master, asynchronous to iCLK
- iADC_CS  in  1  chip select, active-low, asynchronous
- iADC_DIN  in  1  command data from master, asynchronous
- oADC_DOUT  out  1  conversion data to master, MSB first
- oADC_BUSY  out  1  conversion-busy flag
- oADC_PENIRQ_n  out  1  pen interrupt, active-low
- iX_POS  in  12  X sample returned for channel A2..A0 = 3'b101
- iY_POS  in  12  Y sample returned for channel A2..A0 = 3'b001
- iPEN_DOWN  in  1  1 = panel touched
- oCMD  out  8  last accepted control byte {S,A2,A1,A0,MODE,SER/DFR,PD1,PD0}
- oCMD_VALID  out  1  one-iCLK pulse when oCMD updates

## Operation
- Inputs pass through SYNC_STAGES flops, then one edge-detect register. This produces rise/fall strobes for DCLK. All state changes occur only on these strobes or on CS.
- States: IDLE, CMD, CONV, BUSY, DATA.
- IDLE: on a DCLK rise with CS low and DIN = 1 (start bit), load the shift register with 1, set bit count = 1, and go to CMD. Leading zeros are ignored.
- CMD: each DCLK rise shifts DIN in. On the 8th bit:
  - latch oCMD and pulse oCMD_VALID;
  - latch the sample: iX_POS for A = 101, iY_POS for A = 001, 12'h000 otherwise;
  - go to CONV.
- CONV: on the next DCLK fall, set oADC_BUSY = 1 and go to BUSY.
- BUSY: on the next DCLK fall, set oADC_BUSY = 0 and drive oADC_DOUT = the MSB. Go to DATA.
  - MODE = 0: the MSB is sample[11]; 12 bits are sent.
  - MODE = 1: the MSB is sample[11]; 8 bits are sent (sample[11:4]).
- DATA: each later DCLK fall drives the next bit. On the fall after the last bit, drive oADC_DOUT = 0 and go to IDLE.
- DIN is ignored outside IDLE and CMD, so no overlapped start bit is accepted during DATA.
- CS high (synchronized) in any state: go to IDLE immediately and force oADC_BUSY = 0 and oADC_DOUT = 0. oCMD keeps its value.
- oADC_PENIRQ_n = ~iPEN_DOWN, registered.
  - Tracks iPEN_DOWN only in IDLE or while CS is high.
  - Frozen at its last value during CMD, CONV, BUSY and DATA.
- Reset mid-transaction: all state is cleared asynchronously, and the block is in IDLE on the first iCLK after release.

## Timing
- Reset values:
  - oADC_DOUT = 0, oADC_BUSY = 0, oADC_PENIRQ_n = 1
  - oCMD = 8'h00, oCMD_VALID = 0
  - state = IDLE
- Pin-edge to output latency: SYNC_STAGES + 1 iCLK cycles (3 by default) for DOUT, BUSY, oCMD and oCMD_VALID. PENIRQ_n has a latency of 1 cycle (registered; iPEN_DOWN is synchronous).
- Requirement on the master: DCLK high and low phases each ≥ SYNC_STAGES + 2 iCLK cycles, and DIN/CS stable ≥ SYNC_STAGES + 2 cycles around each DCLK rise.
- Per conversion, with start bit on rising edge r1:
  - command on r1..r8;
  - BUSY high from fall f8 to f9;
  - data bits on f9..f20 (12-bit) or f9..f16 (8-bit);
  - DOUT returns to 0 at f21 or f17.
- The master samples bit n on the rise following the fall that drove it.
- oCMD_VALID is exactly 1 iCLK wide, once per accepted byte; it is not asserted for aborted bytes.

## Test plan
- Reset: hold iRST_n low with DCLK toggling -> all outputs at reset values; no oCMD_VALID pulse.
- 12-bit X read: iX_POS = 12'hABC, CS low, send 0xD0 then 16 more clocks.
  - oCMD = 0xD0 with one pulse;
  - BUSY high exactly between f8 and f9;
  - bits sampled on r10..r21 = 1010_1011_1100, then 0s.
- 8-bit Y read with leading zeros: iY_POS = 12'h123, send 3 zero bits, then 0x98 (MODE = 1).
  - oCMD = 0x98;
  - received byte = 0x12, then DOUT = 0.
- Back-to-back: two commands 0xD0 and 0x90 (iY_POS = 12'h5A5) in a single CS-low window, 24 clocks each.
  - returns 0xABC, then 0x5A5;
  - two oCMD_VALID pulses.
- Abort: raise CS after data bit 5 -> BUSY = 0 and DOUT = 0 within 3 iCLK; the next transaction decodes normally.
- Pen: toggle iPEN_DOWN in IDLE -> PENIRQ_n follows within 1 cycle. Toggle it during DATA -> PENIRQ_n unchanged until IDLE.
